// File: rtl/rmdr3_tx.sv
// Serial mod-3 framed transmitter: shifts a word out MSB-first, then appends a
// 2-bit check code so that the whole frame value is divisible by 3.
module rmdr3_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             sval,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK1 = 2'd2,
    CHK0 = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [1:0]       res, res_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [1:0]       chk;

  // MSB-first residue update: r' = (2r + b) mod 3, never reaching 3.
  function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
    logic [1:0] nr;
    case (r)
      2'd0:    nr = b ? 2'd1 : 2'd0;
      2'd1:    nr = b ? 2'd0 : 2'd2;
      2'd2:    nr = b ? 2'd2 : 2'd1;
      default: nr = 2'd0;
    endcase
    return nr;
  endfunction

  // Appending two bits multiplies by 4 == 1 (mod 3), so C = (3 - r) mod 3.
  function automatic logic [1:0] chk_code(input logic [1:0] r);
    logic [1:0] c;
    case (r)
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  assign chk = chk_code(res);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      res   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      res   <= res_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    res_nx   = res;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (load) begin
          sh_nx    = din;
          res_nx   = 2'd0;
          cnt_nx   = CW'(WIDTH);
          state_nx = DATA;
        end
      end
      DATA: begin
        sh_nx  = sh << 1;
        res_nx = res_step(res, sh[WIDTH-1]);
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = CHK1;
      end
      CHK1:    state_nx = CHK0;
      CHK0:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs depend on registered state only; load/din never reach them combinationally.
  always_comb begin
    ready = 1'b0;
    sval  = 1'b0;
    sout  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      DATA: begin
        sval = 1'b1;
        sout = sh[WIDTH-1];
      end
      CHK1: begin
        sval = 1'b1;
        sout = chk[1];
      end
      CHK0: begin
        sval = 1'b1;
        sout = chk[0];
        done = 1'b1;
      end
      default: ready = 1'b1;
    endcase
  end

endmodule
